// File: rtl/wr_mem_line_if.sv
// Pixel stream and MCB write/command port bundle for wr_mem_line.
// The master side is the line writer; the slave side is the FIFO/MCB environment.
interface wr_mem_line_if #(
   parameter int unsigned DWIDTH = 128,
   parameter int unsigned PWIDTH = 16
) ();
   logic                  pix_valid;
   logic [PWIDTH-1:0]     pix_data;
   logic                  pix_ready;
   logic                  mcb_wr_en;
   logic [DWIDTH-1:0]     mcb_wr_data;
   logic [DWIDTH/8-1:0]   mcb_wr_mask;
   logic                  mcb_wr_full;
   logic                  mcb_cmd_en;
   logic [2:0]            mcb_cmd_instr;
   logic [5:0]            mcb_cmd_bl;
   logic [29:0]           mcb_cmd_byte_addr;
   logic                  mcb_cmd_full;

   modport master (
      input  pix_valid, pix_data, mcb_wr_full, mcb_cmd_full,
      output pix_ready, mcb_wr_en, mcb_wr_data, mcb_wr_mask,
             mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr
   );

   modport slave (
      output pix_valid, pix_data, mcb_wr_full, mcb_cmd_full,
      input  pix_ready, mcb_wr_en, mcb_wr_data, mcb_wr_mask,
             mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr
   );
endinterface

// File: rtl/wr_mem_line.sv
// Packs RGB565 pixels 8 per word into the MCB write FIFO and issues WRITE bursts
// using the line/half/eye address map shared with the display reader.
module wr_mem_line #(
   parameter int unsigned DWIDTH     = 128,
   parameter int unsigned PWIDTH     = 16,
   parameter int unsigned BRST_LEN   = 45,
   parameter int unsigned BRST_NUM   = 4,
   parameter int unsigned LINE_DEPTH = 900,
   parameter int unsigned HALF_BYTE  = 720
) (
   input  logic              memclk,
   input  logic              rst,
   input  logic              capture_en,
   input  logic              frame_start,
   wr_mem_line_if.master     bus,
   output logic              line_done,
   output logic [10:0]       linecnt,
   output logic [2:0]        state_dbg
);

   localparam logic [6:0]  WCNT_LAST = 7'(BRST_LEN - 1);
   localparam logic [2:0]  BRST_LAST = 3'(BRST_NUM - 1);
   localparam logic [10:0] LINE_LAST = 11'(LINE_DEPTH - 1);
   localparam logic [12:0] HALF_OFF  = 13'(HALF_BYTE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ISSUE = 3'd2,
      CMD   = 3'd3
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         pcnt_q, pcnt_d;
   logic [6:0]         wcnt_q, wcnt_d;
   logic [2:0]         brstcnt_q, brstcnt_d;
   logic [10:0]        linecnt_q, linecnt_d;
   logic               frame_pending_q, frame_pending_d;
   logic [DWIDTH-1:0]  pack_q, pack_d;
   logic               wr_en_q, wr_en_d;
   logic               cmd_en_q, cmd_en_d;
   logic [29:0]        addr_q, addr_d;
   logic               line_done_q, line_done_d;
   logic               pix_ready;
   logic               pix_accept;

   assign pix_ready  = (state_q == FILL) && !bus.mcb_wr_full;
   assign pix_accept = pix_ready && bus.pix_valid;

   always_comb begin
      state_d         = state_q;
      pcnt_d          = pcnt_q;
      wcnt_d          = wcnt_q;
      brstcnt_d       = brstcnt_q;
      linecnt_d       = linecnt_q;
      pack_d          = pack_q;
      addr_d          = addr_q;
      wr_en_d         = 1'b0;
      cmd_en_d        = 1'b0;
      line_done_d     = 1'b0;
      frame_pending_d = frame_pending_q | (frame_start && (state_q != IDLE));

      case (state_q)
         IDLE: begin
            if (frame_start) linecnt_d = '0;
            if (capture_en) begin
               state_d   = FILL;
               brstcnt_d = '0;
               if (frame_pending_q) begin
                  linecnt_d       = '0;
                  frame_pending_d = 1'b0;
               end
            end
         end
         FILL: begin
            if (pix_accept) begin
               pack_d[pcnt_q*PWIDTH +: PWIDTH] = bus.pix_data;
               pcnt_d = pcnt_q + 3'd1;
               // lane 7 completes the word; the push is registered so it lands next cycle
               if (pcnt_q == 3'd7) begin
                  wr_en_d = 1'b1;
                  wcnt_d  = wcnt_q + 7'd1;
                  if (wcnt_q == WCNT_LAST) state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (!bus.mcb_cmd_full) begin
               cmd_en_d = 1'b1;
               addr_d   = {5'd0, brstcnt_q[1], linecnt_q, (brstcnt_q[0] ? HALF_OFF : 13'd0)};
               state_d  = CMD;
            end
         end
         CMD: begin
            wcnt_d    = '0;
            brstcnt_d = brstcnt_q + 3'd1;
            if (brstcnt_q == BRST_LAST) begin
               line_done_d = 1'b1;
               state_d     = IDLE;
               // a frame_start seen at any point of this line, including now, restarts at line 0
               if (frame_pending_d) begin
                  linecnt_d       = '0;
                  frame_pending_d = 1'b0;
               end else begin
                  linecnt_d = (linecnt_q == LINE_LAST) ? 11'd0 : linecnt_q + 11'd1;
               end
            end else begin
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge memclk) begin
      if (rst) begin
         state_q         <= IDLE;
         pcnt_q          <= '0;
         wcnt_q          <= '0;
         brstcnt_q       <= '0;
         linecnt_q       <= '0;
         frame_pending_q <= 1'b0;
         pack_q          <= '0;
         wr_en_q         <= 1'b0;
         cmd_en_q        <= 1'b0;
         addr_q          <= '0;
         line_done_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         pcnt_q          <= pcnt_d;
         wcnt_q          <= wcnt_d;
         brstcnt_q       <= brstcnt_d;
         linecnt_q       <= linecnt_d;
         frame_pending_q <= frame_pending_d;
         pack_q          <= pack_d;
         wr_en_q         <= wr_en_d;
         cmd_en_q        <= cmd_en_d;
         addr_q          <= addr_d;
         line_done_q     <= line_done_d;
      end
   end

   assign bus.pix_ready         = pix_ready;
   assign bus.mcb_wr_en         = wr_en_q;
   assign bus.mcb_wr_data       = pack_q;
   assign bus.mcb_wr_mask       = '0;
   assign bus.mcb_cmd_en        = cmd_en_q;
   assign bus.mcb_cmd_instr     = 3'd0;
   assign bus.mcb_cmd_bl        = 6'(BRST_LEN - 1);
   assign bus.mcb_cmd_byte_addr = addr_q;
   assign line_done             = line_done_q;
   assign linecnt               = linecnt_q;
   assign state_dbg             = state_q;

endmodule
